// File: rtl/xbar_demux_pkg.sv
// Shared types and constants for the outstanding-transaction-limited crossbar demux.
package xbar_demux_pkg;

  // Transaction-tracking states of the demux.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // nothing outstanding
    ST_ACTIVE = 2'd1,  // transactions outstanding to the locked slave
    ST_DRAIN  = 2'd2   // barrier seen: no new grants until everything returns
  } state_e;

  // Read data returned for an access that decodes to no slave.
  localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

  // Width of the atomic-operation field carried with each request.
  localparam int ATOP_W = 6;

endpackage

// File: rtl/xbar_ot_counter.sv
// Saturating up/down counter of outstanding transactions with full/empty flags.
module xbar_ot_counter #(
  parameter int MAX_OT = 4,
  parameter int CNT_W  = $clog2(MAX_OT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OT);

  logic [CNT_W-1:0] count_q;

  // Count issues up and responses down; a simultaneous pair leaves it unchanged.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && !dec_i && (count_q != MAX_CNT)) begin
      count_q <= count_q + CNT_W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == MAX_CNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/xbar_demux_ot.sv
// One-master to NB_SLAVE-slave demux with an outstanding-transaction limit,
// in-order responses via target locking, barrier drain and decode-error replies.
module xbar_demux_ot
  import xbar_demux_pkg::*;
#(
  parameter  int NB_SLAVE = 4,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int SEL_LSB  = 12,
  parameter  int MAX_OT   = 4,
  localparam int BE_W     = DATA_W / 8,
  localparam int SEL_W    = $clog2(NB_SLAVE),
  localparam int CNT_W    = $clog2(MAX_OT + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // master request
  input  logic                m_req_i,
  input  logic [ADDR_W-1:0]   m_add_i,
  input  logic                m_we_i,
  input  logic [ATOP_W-1:0]   m_atop_i,
  input  logic [DATA_W-1:0]   m_wdata_i,
  input  logic [BE_W-1:0]     m_be_i,
  output logic                m_gnt_o,
  // master control
  input  logic                m_barrier_i,
  input  logic                m_exec_cancel_i,
  input  logic                m_exec_stall_i,
  output logic                m_busy_o,
  // master response
  output logic                m_r_valid_o,
  output logic [DATA_W-1:0]   m_r_rdata_o,
  input  logic                m_r_gnt_i,
  // slave side
  output logic [NB_SLAVE-1:0] s_req_o,
  output logic [ADDR_W-1:0]   s_add_o   [NB_SLAVE],
  output logic [NB_SLAVE-1:0] s_we_o,
  output logic [ATOP_W-1:0]   s_atop_o  [NB_SLAVE],
  output logic [DATA_W-1:0]   s_wdata_o [NB_SLAVE],
  output logic [BE_W-1:0]     s_be_o    [NB_SLAVE],
  input  logic [NB_SLAVE-1:0] s_gnt_i,
  input  logic [NB_SLAVE-1:0] s_r_valid_i,
  input  logic [DATA_W-1:0]   s_r_rdata_i [NB_SLAVE],
  output logic [NB_SLAVE-1:0] s_r_gnt_o
);

  logic [SEL_W-1:0] sel, sel_idx, locked_sel_q;
  logic             dec_err, barrier_block, fwd_ok, req_live;
  logic             fwd, err_gnt, inc, dec, last_rsp;
  logic             rsp_live, rsp_valid_slv, err_pending_q;
  logic             cnt_full, cnt_empty;
  logic [CNT_W-1:0] ot_count;
  state_e           state_q, state_d;

  // Target decode; an out-of-range select is answered locally.
  assign sel     = m_add_i[SEL_LSB +: SEL_W];
  assign dec_err = (int'(sel) >= NB_SLAVE);
  assign sel_idx = dec_err ? '0 : sel;

  // A barrier blocks from the cycle it is seen whenever anything is outstanding.
  assign barrier_block = (state_q == ST_DRAIN) || (m_barrier_i && !cnt_empty);

  // Switching targets is only allowed once everything outstanding has returned,
  // which keeps responses in issue order without a reorder buffer.
  assign fwd_ok = rst_ni && !m_exec_stall_i && !cnt_full && !barrier_block &&
                  !err_pending_q && (cnt_empty || (sel == locked_sel_q));

  assign req_live = rst_ni && m_req_i && !m_exec_cancel_i;
  assign fwd      = req_live && fwd_ok && !dec_err;
  assign err_gnt  = req_live && fwd_ok && dec_err;
  assign inc      = fwd && s_gnt_i[sel_idx];

  // Cancelled requests are acknowledged immediately and never reach a slave.
  assign m_gnt_o = inc || err_gnt || (rst_ni && m_req_i && m_exec_cancel_i);

  // Response path follows the locked target; a pending decode error takes priority.
  assign rsp_live      = !cnt_empty && !err_pending_q;
  assign rsp_valid_slv = rsp_live && s_r_valid_i[locked_sel_q];
  assign dec           = rsp_valid_slv && m_r_gnt_i;
  assign m_r_valid_o   = err_pending_q || rsp_valid_slv;
  assign m_r_rdata_o   = err_pending_q ? DATA_W'(ERR_RDATA) : s_r_rdata_i[locked_sel_q];
  assign m_busy_o      = !cnt_empty || err_pending_q;

  assign s_we_o = {NB_SLAVE{m_we_i}};

  // Broadcast the request payload, one-hot request and response grant.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    s_req_o   = '0;
    s_r_gnt_o = '0;
    for (int i = 0; i < NB_SLAVE; i++) begin
      s_add_o[i]   = m_add_i;
      s_atop_o[i]  = m_atop_i;
      s_wdata_o[i] = m_wdata_i;
      s_be_o[i]    = m_be_i;
    end
    if (fwd) s_req_o[sel_idx] = 1'b1;
    if (rsp_live) s_r_gnt_o[locked_sel_q] = m_r_gnt_i;
  end

  xbar_ot_counter #(
    .MAX_OT (MAX_OT),
    .CNT_W  (CNT_W)
  ) u_ot_counter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (inc),
    .dec_i   (dec),
    .count_o (ot_count),
    .full_o  (cnt_full),
    .empty_o (cnt_empty)
  );

  // Lock the target of each slave grant and track the local error reply.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_sel_q  <= '0;
      err_pending_q <= 1'b0;
    end else begin
      if (inc) locked_sel_q <= sel;
      if (err_gnt) begin
        err_pending_q <= 1'b1;
      end else if (err_pending_q && m_r_gnt_i) begin
        err_pending_q <= 1'b0;
      end
    end
  end

  // The final outstanding response returns with no new issue in the same cycle.
  assign last_rsp = dec && !inc && (ot_count == CNT_W'(1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: a barrier only matters while something is outstanding.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (inc) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (last_rsp)         state_d = ST_IDLE;
        else if (m_barrier_i) state_d = ST_DRAIN;
      end
      ST_DRAIN:  if (last_rsp) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

endmodule
